// File: rtl/teller_dispatcher.sv
// teller_dispatcher: hands queued ticket numbers from the ticket FIFO to teller counters.
//
// The block is the FIFO's only reader. It arbitrates round-robin among requesting tellers,
// pops one ticket per dispatch and delivers it with a one-hot, single-cycle grant. Each
// dispatch runs IDLE -> ISSUE -> CAPTURE -> GRANT, so throughput is at most one ticket
// every four cycles.
//
// A teller that has been served is masked until it drops its request for at least one
// cycle, so a held request never collects two tickets.
//
// Optional feature (macro DISPATCH_PRIO_EN): teller 0 is a priority desk. It wins whenever
// it is eligible, tellers 1..N_TELLERS-1 round-robin among themselves, and the round-robin
// pointer does not move when teller 0 is served. Undefined: pure round-robin.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   teller_req    level request per teller, "ready for next customer"
//   fifo_empty    FIFO empty flag, sampled only in IDLE
//   fifo_data     FIFO read data, valid the cycle after fifo_rd
//   fifo_rd       FIFO read strobe, one cycle per ticket
//   teller_grant  one-hot, one cycle, to the teller being served
//   ticket        last dispatched ticket, held until the next dispatch
//   ticket_valid  high together with teller_grant
//   served_cnt    saturating count of dispatched tickets
//   busy          high whenever a dispatch is in progress
module teller_dispatcher #(
  parameter int unsigned N_TELLERS = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_TELLERS-1:0] teller_req,
  input  logic                 fifo_empty,
  input  logic [DATA_W-1:0]    fifo_data,
  output logic                 fifo_rd,
  output logic [N_TELLERS-1:0] teller_grant,
  output logic [DATA_W-1:0]    ticket,
  output logic                 ticket_valid,
  output logic [CNT_W-1:0]     served_cnt,
  output logic                 busy
);

  localparam int unsigned     IdxW    = (N_TELLERS > 1) ? $clog2(N_TELLERS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_TELLERS - 1);
  localparam logic [IdxW:0]   NumT    = (IdxW + 1)'(N_TELLERS);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StGrant} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        winner_q, winner_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [N_TELLERS-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]      ticket_q, ticket_d;
  logic [CNT_W-1:0]       served_q, served_d;

  logic [N_TELLERS-1:0]   eligible;
  logic [N_TELLERS-1:0]   rr_elig;
  logic [IdxW:0]          cand;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_found;
  logic [IdxW-1:0]        next_rr;

  assign eligible = teller_req & mask_q;
  assign next_rr  = (winner_q == LastIdx) ? '0 : winner_q + IdxW'(1);

  // Winner search: first eligible bit at or above rr_q, wrapping past the last teller.
  always_comb begin
    rr_elig    = eligible;
`ifdef DISPATCH_PRIO_EN
    rr_elig[0] = 1'b0;
`endif
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N_TELLERS; k++) begin
      cand = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (cand >= NumT) begin
        cand = cand - NumT;
      end
      if (!pick_found && rr_elig[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
`ifdef DISPATCH_PRIO_EN
    if (eligible[0]) begin
      pick_found = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_d     = rr_q;
    ticket_d = ticket_q;
    served_d = served_q;
    // A dropped request re-arms that teller; clearing on grant below takes precedence.
    mask_d   = mask_q | ~teller_req;
    unique case (state_q)
      StIdle: begin
        if (pick_found && !fifo_empty) begin
          winner_d = pick_idx;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        // Ticket and count are registered here so both are visible alongside the grant.
        ticket_d = fifo_data;
        if (served_q != CntMax) begin
          served_d = served_q + CNT_W'(1);
        end
        state_d = StGrant;
      end
      StGrant: begin
        mask_d[winner_q] = 1'b0;
`ifdef DISPATCH_PRIO_EN
        if (winner_q != '0) begin
          rr_d = next_rr;
        end
`else
        rr_d = next_rr;
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      winner_q <= '0;
      rr_q     <= '0;
      mask_q   <= '1;
      ticket_q <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      mask_q   <= mask_d;
      ticket_q <= ticket_d;
      served_q <= served_d;
    end
  end

  always_comb begin
    teller_grant = '0;
    if (state_q == StGrant) begin
      teller_grant[winner_q] = 1'b1;
    end
  end

  assign fifo_rd      = (state_q == StIssue);
  assign ticket_valid = (state_q == StGrant);
  assign busy         = (state_q != StIdle);
  assign ticket       = ticket_q;
  assign served_cnt   = served_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Testbench for teller_dispatcher: a behavioural FIFO plus a transaction-level reference
// model (dispatch phase counter, integer round-robin pointer, ticket index into the FIFO
// contents). A small CNT_W makes counter saturation reachable quickly.
module tb_teller_dispatcher;

  localparam int NT     = 3;
  localparam int DW     = 8;
  localparam int CW     = 4;
  localparam int OW     = NT + DW + CW + 3;
  localparam int SatMax = (1 << CW) - 1;
  localparam int MemSz  = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NT-1:0] teller_req = '0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd;
  logic [NT-1:0] teller_grant;
  logic [DW-1:0] ticket;
  logic          ticket_valid;
  logic [CW-1:0] served_cnt;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  teller_dispatcher #(
    .N_TELLERS(NT),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .teller_req  (teller_req),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .teller_grant(teller_grant),
    .ticket      (ticket),
    .ticket_valid(ticket_valid),
    .served_cnt  (served_cnt),
    .busy        (busy)
  );

  // Ticket FIFO: data appears the cycle after the read strobe.
  logic [DW-1:0] mem [MemSz];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd && rd_ptr < wr_ptr) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    if (wr_ptr < MemSz) begin
      mem[wr_ptr] = v;
      wr_ptr++;
    end
  endtask

  // Reference model: phase 0 idle, 1 reading, 2 capturing, 3 delivering.
  int            m_phase  = 0;
  int            m_win    = 0;
  int            m_rr     = 0;
  int            m_pop    = 0;
  int            m_served = 0;
  logic [NT-1:0] m_mask   = '1;
  logic [DW-1:0] m_hold   = '0;
  logic [DW-1:0] m_ticket = '0;

  function automatic int pick(input logic [NT-1:0] e, input int rr);
`ifdef DISPATCH_PRIO_EN
    if (e[0]) return 0;
    e[0] = 1'b0;
`endif
    for (int k = 0; k < NT; k++) begin
      if (e[(rr + k) % NT]) return (rr + k) % NT;
    end
    return 0;
  endfunction

  function automatic logic [NT-1:0] upd_mask(input logic [NT-1:0] m, input logic [NT-1:0] req,
                                             input bit clr, input int w);
    logic [NT-1:0] r;
    r = m | ~req;
    if (clr) r[w] = 1'b0;
    return r;
  endfunction

  function automatic int next_rr(input int w, input int rr);
`ifdef DISPATCH_PRIO_EN
    if (w == 0) return rr;
`endif
    return (w + 1) % NT;
  endfunction

  always @(posedge clk) begin
    // The FIFO pops on a read strobe even if reset arrives in the same cycle.
    if (m_phase == 1) m_pop <= m_pop + 1;
    if (!rst_n) begin
      m_phase  <= 0;
      m_win    <= 0;
      m_rr     <= 0;
      m_mask   <= '1;
      m_ticket <= '0;
      m_served <= 0;
    end else begin
      m_mask <= upd_mask(m_mask, teller_req, m_phase == 3, m_win);
      case (m_phase)
        0: begin
          if ((teller_req & m_mask) != '0 && m_pop != wr_ptr) begin
            m_win   <= pick(teller_req & m_mask, m_rr);
            m_phase <= 1;
          end
        end
        1: begin
          m_hold  <= mem[m_pop];
          m_phase <= 2;
        end
        2: begin
          m_ticket <= m_hold;
          m_served <= (m_served >= SatMax) ? SatMax : m_served + 1;
          m_phase  <= 3;
        end
        default: begin
          m_rr    <= next_rr(m_win, m_rr);
          m_phase <= 0;
        end
      endcase
    end
  end

  logic [NT-1:0] exp_grant;
  logic [OW-1:0] exp_v;
  logic [OW-1:0] obs_v;
  assign exp_grant = (m_phase == 3) ? NT'(1 << m_win) : '0;
  assign exp_v = {m_phase == 1, exp_grant, m_ticket, m_phase == 3, CW'(m_served), m_phase != 0};
  assign obs_v = {fifo_rd, teller_grant, ticket, ticket_valid, served_cnt, busy};

  // Advance to the next falling edge and drive requests; with drop set, a teller granted in
  // the previous cycle releases its request for exactly one cycle.
  logic [NT-1:0] pend_drop = '0;
  task automatic next_cycle(input logic [NT-1:0] base, input bit drop);
    @(negedge clk);
    teller_req = base & ~(drop ? pend_drop : '0);
    pend_drop  = drop ? exp_grant : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle('0, 1'b0);
    n_checks++;
    if (obs_v !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs dut=%h want=%h", obs_v, {OW{1'b0}});
    end
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL reset_model dut=%h model=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_single();
    next_cycle(3'b001, 1'b0);
    push(8'h01);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle(3'b001, 1'b0);
      n_checks++;
      if (fifo_rd !== (c == 1)) begin
        n_errors++;
        $display("FAIL single_rd cyc=%0d dut=%b want=%b", c, fifo_rd, c == 1);
      end
      if (c == 3) begin
        n_checks++;
        if (teller_grant !== 3'b001 || ticket !== 8'h01 || served_cnt !== CW'(1)) begin
          n_errors++;
          $display("FAIL single_grant dut=%b/%h/%0d want=001/01/1", teller_grant, ticket,
                   served_cnt);
        end
      end
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL single_model cyc=%0d dut=%h model=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NT-1:0] got  [6];
    logic [DW-1:0] tk   [6];
    logic [NT-1:0] want [6];
    int n = 0;
`ifdef DISPATCH_PRIO_EN
    want = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
`else
    want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    for (int i = 0; i < 6; i++) begin
      got[i] = '0;
      tk[i]  = '0;
    end
    rst_n = 1'b0;
    next_cycle('0, 1'b0);
    next_cycle('0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) push(DW'(i));
    for (int c = 0; c < 60 && n < 6; c++) begin
      next_cycle('1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL rr_model cyc=%0d dut=%h model=%h", c, obs_v, exp_v);
      end
      if (teller_grant !== '0) begin
        got[n] = teller_grant;
        tk[n]  = ticket;
        n++;
      end
    end
    n_checks++;
    if (n !== 6) begin
      n_errors++;
      $display("FAIL rr_count dut=%0d want=6", n);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got[i] !== want[i] || tk[i] !== DW'(i + 1)) begin
        n_errors++;
        $display("FAIL rr_order idx=%0d dut=%b/%h want=%b/%h", i, got[i], tk[i], want[i],
                 DW'(i + 1));
      end
    end
  endtask

  task automatic test_empty_wait();
    bit seen = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle('0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      next_cycle(3'b010, 1'b0);
      n_checks++;
      if (fifo_rd !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL empty_idle cyc=%0d dut=%b/%b want=0/0", c, fifo_rd, busy);
      end
    end
    push(8'h2A);
    for (int c = 0; c < 10 && !seen; c++) begin
      next_cycle(3'b010, 1'b0);
      if (teller_grant !== '0) seen = 1'b1;
    end
    n_checks++;
    if (teller_grant !== 3'b010 || ticket !== 8'h2A) begin
      n_errors++;
      $display("FAIL empty_then_grant dut=%b/%h want=010/2a", teller_grant, ticket);
    end
  endtask

  task automatic test_no_regrant();
    bit seen = 1'b0;
    push(8'h31);
    push(8'h32);
    for (int c = 0; c < 20; c++) begin
      next_cycle(3'b010, 1'b0);
      n_checks++;
      if (teller_grant !== '0 || fifo_rd !== 1'b0) begin
        n_errors++;
        $display("FAIL held_no_regrant cyc=%0d dut=%b/%b want=000/0", c, teller_grant, fifo_rd);
      end
    end
    next_cycle('0, 1'b0);
    for (int c = 0; c < 10 && !seen; c++) begin
      next_cycle(3'b010, 1'b0);
      if (teller_grant !== '0) seen = 1'b1;
    end
    n_checks++;
    if (teller_grant !== 3'b010 || ticket !== 8'h31) begin
      n_errors++;
      $display("FAIL rearm_grant dut=%b/%h want=010/31", teller_grant, ticket);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) push(DW'(8'h40 + i));
    for (int c = 0; c < 80; c++) begin
      next_cycle('1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL sat_model cyc=%0d dut=%h model=%h", c, obs_v, exp_v);
      end
    end
    n_checks++;
    if (served_cnt !== CW'(SatMax)) begin
      n_errors++;
      $display("FAIL sat_count dut=%0d want=%0d", served_cnt, SatMax);
    end
    n_checks++;
    if (rd_ptr !== wr_ptr) begin
      n_errors++;
      $display("FAIL sat_drained dut_popped=%0d want=%0d", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle('0, 1'b0);
    push(8'h77);
    for (int c = 0; c < 10 && !found; c++) begin
      next_cycle(3'b001, 1'b0);
      if (m_phase == 2) found = 1'b1;
    end
    n_checks++;
    if (busy !== 1'b1 || fifo_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL capture_reached dut=%b/%b want=1/0", busy, fifo_rd);
    end
    rst_n = 1'b0;
    next_cycle(3'b001, 1'b0);
    n_checks++;
    if (obs_v !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs dut=%h want=%h", obs_v, {OW{1'b0}});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle('0, 1'b0);
      n_checks++;
      if (teller_grant !== '0 || obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_after cyc=%0d dut=%h model=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [NT-1:0] base = '1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) base[$urandom_range(0, NT - 1)] ^= 1'b1;
      next_cycle(base, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) push(DW'($urandom));
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d dut=%h model=%h", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_empty_wait();
    test_no_regrant();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
